// File: rtl/instr_packer_pkg.sv
// Shared definitions for the immediate packer: immediate-format encodings
// and the sign-extension legality helper.
package instr_packer_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // True when v[31:lo] are all copies of the sign bit, i.e. the value
    // survives truncation to lo+1 bits and sign extension back to 32.
    function automatic logic sext_ok(input logic [31:0] v, input int unsigned lo);
        logic [31:0] s;
        s = $signed(v) >>> lo;
        return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_packer_imm_pack.sv
// Combinational immediate scatter: places imm into the format-specific
// instruction bits of base and reports whether imm is encodable.
module imm_pack
    import instr_packer_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] word,
    output logic        legal
);

    // Field placement and encodability per immediate format
    always_comb begin
        word  = base;
        legal = 1'b0;
        case (imm_src)
            IMM_I: begin
                word[31:20] = imm[11:0];
                legal       = sext_ok(imm, 11);
            end
            IMM_S: begin
                word[31:25] = imm[11:5];
                word[11:7]  = imm[4:0];
                legal       = sext_ok(imm, 11);
            end
            IMM_B: begin
                word[31]    = imm[12];
                word[30:25] = imm[10:5];
                word[11:8]  = imm[4:1];
                word[7]     = imm[11];
                legal       = sext_ok(imm, 12) && !imm[0];
            end
            IMM_J: begin
                word[31]    = imm[20];
                word[30:21] = imm[10:1];
                word[20]    = imm[11];
                word[19:12] = imm[19:12];
                legal       = sext_ok(imm, 20) && !imm[0];
            end
            IMM_U: begin
                word[31:12] = imm[31:12];
                legal       = (imm[11:0] == 12'h000);
            end
            default: begin
                word  = base;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// Instruction-memory loader: packs immediates into instruction words and
// writes them to consecutive addresses, stopping on full or on an error.
module instr_packer
    import instr_packer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [31:0]       imm,
    input  logic [31:0]       base,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              full
);

    logic [ADDR_W-1:0] ptr_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [31:0]       wr_data_r;
    logic              err_r;
    logic [ADDR_W-1:0] err_addr_r;
    logic              full_r;
    logic [31:0]       word_s;
    logic              legal_s;
    logic              accept_s;

    imm_pack u_imm_pack (
        .imm_src (imm_src),
        .imm     (imm),
        .base    (base),
        .word    (word_s),
        .legal   (legal_s)
    );

    assign in_ready = !err_r && !full_r && !clear;
    assign accept_s = in_valid && in_ready;

    // Pointer, sticky flags and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= {ADDR_W{1'b0}};
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            wr_data_r  <= 32'h0000_0000;
            err_r      <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
            full_r     <= 1'b0;
        end else begin
            // accept_s is already gated by clear, so a clear cycle never writes
            wr_en_r <= accept_s && legal_s;
            if (clear) begin
                ptr_r      <= {ADDR_W{1'b0}};
                err_r      <= 1'b0;
                err_addr_r <= {ADDR_W{1'b0}};
                full_r     <= 1'b0;
            end else if (accept_s && legal_s) begin
                wr_addr_r <= ptr_r;
                wr_data_r <= word_s;
                ptr_r     <= ptr_r + ADDR_W'(1'b1);
                full_r    <= &ptr_r;
            end else if (accept_s) begin
                err_r      <= 1'b1;
                err_addr_r <= ptr_r;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign err      = err_r;
    assign err_addr = err_addr_r;
    assign full     = full_r;

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer with a per-cycle reference model built
// from the encoding rules (signed ranges and bit concatenations).
module tb_instr_packer;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    imm_src = 3'b000;
    logic [31:0]   imm = 32'h0;
    logic [31:0]   base = 32'h0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          err;
    logic [AW-1:0] err_addr;
    logic          full;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    instr_packer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .imm_src(imm_src), .imm(imm), .base(base),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err(err), .err_addr(err_addr), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding: {legal, word}
    function automatic logic [32:0] model_pack(input logic [2:0] src, input logic [31:0] v,
                                               input logic [31:0] b);
        longint s;
        logic   ok;
        logic [31:0] w;
        s  = longint'($signed(v));
        ok = 1'b0;
        w  = b;
        case (src)
            3'd0: begin ok = (s >= -2048 && s <= 2047); w = {v[11:0], b[19:0]}; end
            3'd1: begin ok = (s >= -2048 && s <= 2047); w = {v[11:5], b[24:12], v[4:0], b[6:0]}; end
            3'd2: begin ok = (s >= -4096 && s <= 4095) && (s % 2 == 0);
                        w = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]}; end
            3'd3: begin ok = (s >= -(64'sd1 << 20) && s < (64'sd1 << 20)) && (s % 2 == 0);
                        w = {v[20], v[10:1], v[11], v[19:12], b[11:0]}; end
            3'd4: begin ok = (v % 4096 == 0); w = {v[31:12], b[11:0]}; end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    int          m_ptr = 0;
    bit          m_err = 1'b0;
    bit          m_full = 1'b0;
    int          m_err_addr = 0;
    bit          m_wr_en = 1'b0;
    int          m_wr_addr = 0;
    logic [31:0] m_wr_data = 32'h0;

    // Model state advances on each rising edge
    always @(posedge clk) begin
        logic [32:0] p;
        p = model_pack(imm_src, imm, base);
        m_wr_en <= 1'b0;
        if (rst) begin
            m_ptr <= 0; m_err <= 1'b0; m_full <= 1'b0; m_err_addr <= 0;
        end else if (clear) begin
            m_ptr <= 0; m_err <= 1'b0; m_full <= 1'b0; m_err_addr <= 0;
        end else if (in_valid && !m_err && !m_full) begin
            if (p[32]) begin
                m_wr_en   <= 1'b1;
                m_wr_addr <= m_ptr;
                m_wr_data <= p[31:0];
                m_ptr     <= (m_ptr + 1) % DEPTH;
                if (m_ptr == DEPTH - 1) m_full <= 1'b1;
            end else begin
                m_err      <= 1'b1;
                m_err_addr <= m_ptr;
            end
        end
    end

    // Compare DUT against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en", {31'b0, wr_en}, {31'b0, m_wr_en});
            chk("err", {31'b0, err}, {31'b0, m_err});
            chk("full", {31'b0, full}, {31'b0, m_full});
            chk("err_addr", 32'(err_addr), 32'(m_err_addr));
            chk("in_ready", {31'b0, in_ready}, {31'b0, !m_err && !m_full && !clear});
            if (m_wr_en) begin
                chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
                chk("wr_data", wr_data, m_wr_data);
            end
        end
    end

    // One-cycle request; returns #1 after the accepting edge
    task automatic send(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
        imm_src = s; imm = v; base = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        logic [32:0] p;
        // Pin the model on the hand-computed vectors
        p = model_pack(3'd0, 32'hFFFF_F800, 32'h13); chk("m_I", p[31:0], 32'h8000_0013);
        p = model_pack(3'd2, 32'hFFFF_FFFE, 32'h63); chk("m_B", p[31:0], 32'hFE00_0FE3);
        p = model_pack(3'd3, 32'h000F_FFFE, 32'h6F); chk("m_J", p[31:0], 32'h7FFF_F06F);
        p = model_pack(3'd4, 32'h1234_5001, 32'h37); chk("m_U_bad", {31'b0, p[32]}, 32'd0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);

        send(3'd0, 32'hFFFF_F800, 32'h13);
        chk("I_wr_en", {31'b0, wr_en}, 32'd1);
        chk("I_addr", 32'(wr_addr), 32'd0);
        chk("I_data", wr_data, 32'h8000_0013);
        @(posedge clk); #1;
        chk("idle_wr_en", {31'b0, wr_en}, 32'd0);
        send(3'd0, 32'h0000_0800, 32'h13);
        chk("I_bad_err", {31'b0, err}, 32'd1);
        chk("I_bad_addr", 32'(err_addr), 32'd1);
        chk("I_bad_wr", {31'b0, wr_en}, 32'd0);

        // Clear with a request pending while in error
        imm_src = 3'd0; imm = 32'h5; base = 32'h13; in_valid = 1'b1; clear = 1'b1;
        #1 chk("clr_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_err", {31'b0, err}, 32'd0);
        chk("clr_wr", {31'b0, wr_en}, 32'd0);
        send(3'd4, 32'h1234_5000, 32'h37);
        chk("U_addr", 32'(wr_addr), 32'd0);
        chk("U_data", wr_data, 32'h1234_5037);
        send(3'd2, 32'hFFFF_FFFE, 32'h63);
        chk("B_data", wr_data, 32'hFE00_0FE3);
        send(3'd3, 32'h000F_FFFE, 32'h6F);
        chk("J_data", wr_data, 32'h7FFF_F06F);
        send(3'd2, 32'h0000_0003, 32'h63);
        chk("B_bad_err", {31'b0, err}, 32'd1);
        chk("B_bad_addr", 32'(err_addr), 32'd3);
        do_clear();
        send(3'd1, 32'hFFFF_FFFF, 32'h23);
        chk("S_data", wr_data, 32'hFE00_0FA3);
        send(3'd4, 32'h1234_5001, 32'h37);
        chk("U_bad_err", {31'b0, err}, 32'd1);
        do_clear();
        send(3'd5, 32'h0, 32'h13);
        chk("src5_err", {31'b0, err}, 32'd1);
        do_clear();

        // Fill all DEPTH words back to back, then try one more
        imm_src = 3'd0; base = 32'h13; imm = 32'd0; in_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            imm = 32'(i + 1);
            if (i < DEPTH) begin
                chk("fill_wr_en", {31'b0, wr_en}, 32'd1);
                chk("fill_addr", 32'(wr_addr), 32'(i));
            end else begin
                chk("fill_extra_wr", {31'b0, wr_en}, 32'd0);
            end
        end
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        do_clear();

        // Reset right after an accept aborts nothing further
        send(3'd0, 32'h7, 32'h13);
        chk("pre_rst_wr", {31'b0, wr_en}, 32'd1);
        send(3'd0, 32'h9, 32'h13);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        chk("mid_rst_full", {31'b0, full}, 32'd0);
        send(3'd0, 32'h1, 32'h13);
        chk("post_rst_addr", 32'(wr_addr), 32'd0);
        chk("post_rst_data", wr_data, 32'h0010_0013);
        @(posedge clk); #1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
